// File: rtl/spine_switch_if.sv
// Leaf-side bus of the spine crossbar: per-leaf flit inputs, routed flit outputs and
// per-input buffer status. The switch uses the slave view.
interface spine_switch_if #(
  parameter int DWIDTH     = 16,
  parameter int NUM_LEAVES = 4
);
  logic [NUM_LEAVES*DWIDTH-1:0] leaf_in_data;
  logic [NUM_LEAVES-1:0]        leaf_in_valid;
  logic [NUM_LEAVES*DWIDTH-1:0] leaf_out_data;
  logic [NUM_LEAVES-1:0]        leaf_out_valid;
  logic [NUM_LEAVES*6-1:0]      leaf_out_dest;
  logic [NUM_LEAVES*8-1:0]      drop_count;
  logic [NUM_LEAVES-1:0]        fifo_full;
  logic [NUM_LEAVES-1:0]        fifo_empty;

  modport master (
    output leaf_in_data, leaf_in_valid,
    input  leaf_out_data, leaf_out_valid, leaf_out_dest, drop_count, fifo_full, fifo_empty
  );

  modport slave (
    input  leaf_in_data, leaf_in_valid,
    output leaf_out_data, leaf_out_valid, leaf_out_dest, drop_count, fifo_full, fifo_empty
  );
endinterface

// File: rtl/spine_switch.sv
// Spine crossbar: per-leaf input FIFOs, per-output round-robin arbitration and
// registered outputs. Valid-only links, so overflowing flits are dropped and counted.
module spine_switch #(
  parameter int DWIDTH     = 16,
  parameter int NUM_LEAVES = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int SEL_LSB    = 12,
  parameter int DEST_MSB   = 15
) (
  input logic           ACLK,
  input logic           ARESETn,
  spine_switch_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  logic [NUM_LEAVES-1:0]        req;
  logic [NUM_LEAVES*2-1:0]      sel_flat;
  logic [NUM_LEAVES*DWIDTH-1:0] head_flat;
  logic [NUM_LEAVES-1:0]        gnt_vld;
  logic [NUM_LEAVES*2-1:0]      gnt_idx_flat;

  generate
    for (genvar gi = 0; gi < NUM_LEAVES; gi++) begin : g_leaf
      logic [DWIDTH-1:0] mem_reg [FIFO_DEPTH];
      logic [PW-1:0]     wr_ptr_reg;
      logic [PW-1:0]     rd_ptr_reg;
      logic [7:0]        drop_reg;
      logic              empty;
      logic              full;
      logic              pop;
      logic              in_valid;
      logic              accept;
      logic [DWIDTH-1:0] in_data;
      logic [DWIDTH-1:0] head;

      assign in_valid = bus.leaf_in_valid[gi];
      assign in_data  = bus.leaf_in_data[gi*DWIDTH +: DWIDTH];
      assign empty    = (wr_ptr_reg == rd_ptr_reg);
      assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
      assign head     = mem_reg[rd_ptr_reg[AW-1:0]];
      // A full FIFO still accepts when its head leaves on the same edge.
      assign accept   = in_valid && (!full || pop);

      always_comb begin
        pop = 1'b0;
        for (int o = 0; o < NUM_LEAVES; o++) begin
          if (gnt_vld[o] && (gnt_idx_flat[o*2 +: 2] == 2'(gi))) pop = 1'b1;
        end
      end

      always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          drop_reg   <= '0;
        end else begin
          if (accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop)    rd_ptr_reg <= rd_ptr_reg + 1'b1;
          if (in_valid && full && !pop && (drop_reg != 8'hFF)) drop_reg <= drop_reg + 8'd1;
        end
      end

      always_ff @(posedge ACLK) begin
        if (accept) mem_reg[wr_ptr_reg[AW-1:0]] <= in_data;
      end

      assign req[gi]                        = !empty;
      assign sel_flat[gi*2 +: 2]            = head[SEL_LSB +: 2];
      assign head_flat[gi*DWIDTH +: DWIDTH] = head;
      assign bus.drop_count[gi*8 +: 8]      = drop_reg;
      assign bus.fifo_full[gi]              = full;
      assign bus.fifo_empty[gi]             = empty;
    end

    for (genvar go = 0; go < NUM_LEAVES; go++) begin : g_out
      logic [1:0]        rr_ptr_reg;
      logic [1:0]        cand;
      logic [1:0]        win;
      logic              grant;
      logic [DWIDTH-1:0] win_flit;
      logic [DWIDTH-1:0] data_reg;
      logic [5:0]        dest_reg;
      logic              valid_reg;

      // Search starts one past the last winner, so the last winner has lowest priority.
      always_comb begin
        grant = 1'b0;
        win   = rr_ptr_reg;
        cand  = rr_ptr_reg;
        for (int k = 1; k <= NUM_LEAVES; k++) begin
          cand = rr_ptr_reg + 2'(k);
          if (!grant && req[cand] && (sel_flat[cand*2 +: 2] == 2'(go))) begin
            grant = 1'b1;
            win   = cand;
          end
        end
      end

      assign win_flit = head_flat[win*DWIDTH +: DWIDTH];

      always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
          rr_ptr_reg <= 2'(NUM_LEAVES - 1);
          valid_reg  <= 1'b0;
          data_reg   <= '0;
          dest_reg   <= '0;
        end else begin
          valid_reg <= grant;
          if (grant) begin
            rr_ptr_reg <= win;
            data_reg   <= win_flit;
            dest_reg   <= win_flit[DEST_MSB -: 6];
          end
        end
      end

      assign gnt_vld[go]                        = grant;
      assign gnt_idx_flat[go*2 +: 2]            = win;
      assign bus.leaf_out_valid[go]             = valid_reg;
      assign bus.leaf_out_data[go*DWIDTH +: DWIDTH] = data_reg;
      assign bus.leaf_out_dest[go*6 +: 6]       = dest_reg;
    end
  endgenerate
endmodule
